// File: rtl/pace_pkg.sv
// Shared types and reset defaults for the demand-pacing scheduler.
package pace_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAlert   = 2'd1,
    StPace    = 2'd2,
    StRefract = 2'd3
  } pace_state_t;

  localparam int unsigned DEF_ESCAPE = 200;
  localparam int unsigned DEF_REFR   = 60;
  localparam int unsigned DEF_PULSE  = 2;

endpackage

// File: rtl/beat_sync.sv
// Two-flop synchroniser for the sensed-beat level plus a one-cycle rising-edge strobe.
module beat_sync (
  input  logic clk_2,
  input  logic reset_n,
  input  logic beat_sense,
  output logic beat_rise
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= beat_sense;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign beat_rise = sync_q & ~prev_q;

endmodule

// File: rtl/pace_scheduler.sv
// Demand-pacing scheduler: escape/pulse/refractory windows timed in ticks.
// Define PACE_STATS_EN to add saturating paced/sensed event counters.
module pace_scheduler
  import pace_pkg::*;
#(
  parameter int unsigned CNT_BITS   = 8,
  parameter int unsigned PULSE_BITS = 4,
  parameter int unsigned STAT_BITS  = 8
) (
  input  logic                  clk_2,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  enable,
  input  logic                  beat_sense,
  input  logic                  cfg_we,
  input  logic [CNT_BITS-1:0]   escape_lim,
  input  logic [CNT_BITS-1:0]   refr_lim,
  input  logic [PULSE_BITS-1:0] pulse_len,
  input  logic                  alarm_clr,
  output logic                  pace,
  output logic                  alarm,
  output logic [1:0]            state_o
`ifdef PACE_STATS_EN
  ,
  output logic [STAT_BITS-1:0]  paced_cnt,
  output logic [STAT_BITS-1:0]  sensed_cnt
`endif
);

  pace_state_t state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CNT_BITS-1:0]   esc_sh_q, refr_sh_q;
  logic [PULSE_BITS-1:0] pulse_sh_q;
  logic [CNT_BITS-1:0]   esc_act_q, refr_act_q;
  logic [PULSE_BITS-1:0] pulse_act_q;
  logic [CNT_BITS-1:0]   esc_eff, refr_eff, pulse_eff;
  logic                  alarm_q, alarm_d, pace_q;
  logic                  load_act, paced_ev, sensed_ev, beat_rise;

  beat_sync u_beat_sync (
    .clk_2      (clk_2),
    .reset_n    (reset_n),
    .beat_sense (beat_sense),
    .beat_rise  (beat_rise)
  );

  // A programmed limit of zero behaves as a one-tick window.
  assign esc_eff   = (esc_act_q == '0) ? CNT_BITS'(1) : esc_act_q;
  assign refr_eff  = (refr_act_q == '0) ? CNT_BITS'(1) : refr_act_q;
  assign pulse_eff = (pulse_act_q == '0) ? CNT_BITS'(1) : CNT_BITS'(pulse_act_q);
  assign cnt_inc   = cnt_q + CNT_BITS'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alarm_d   = alarm_q;
    load_act  = 1'b0;
    paced_ev  = 1'b0;
    sensed_ev = 1'b0;
    if (alarm_clr) begin
      alarm_d = 1'b0;
    end
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StAlert;
          cnt_d    = '0;
          load_act = 1'b1;
        end
        StAlert: begin
          // A sensed beat outranks an escape expiring in the same cycle.
          if (beat_rise) begin
            state_d   = StRefract;
            cnt_d     = '0;
            load_act  = 1'b1;
            sensed_ev = 1'b1;
          end else if (tick) begin
            if (cnt_inc == esc_eff) begin
              state_d  = StPace;
              cnt_d    = '0;
              paced_ev = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        StPace: begin
          if (tick) begin
            if (cnt_inc == pulse_eff) begin
              state_d  = StRefract;
              cnt_d    = '0;
              load_act = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        StRefract: begin
          if (beat_rise) begin
            alarm_d = 1'b1;
          end
          if (tick) begin
            if (cnt_inc == refr_eff) begin
              state_d = StAlert;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      alarm_q     <= 1'b0;
      pace_q      <= 1'b0;
      esc_sh_q    <= CNT_BITS'(DEF_ESCAPE);
      refr_sh_q   <= CNT_BITS'(DEF_REFR);
      pulse_sh_q  <= PULSE_BITS'(DEF_PULSE);
      esc_act_q   <= CNT_BITS'(DEF_ESCAPE);
      refr_act_q  <= CNT_BITS'(DEF_REFR);
      pulse_act_q <= PULSE_BITS'(DEF_PULSE);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
      pace_q  <= (state_d == StPace);
      if (cfg_we) begin
        esc_sh_q   <= escape_lim;
        refr_sh_q  <= refr_lim;
        pulse_sh_q <= pulse_len;
      end
      // Windows latch their lengths on entry so a mid-window load waits its turn.
      if (load_act) begin
        esc_act_q   <= esc_sh_q;
        refr_act_q  <= refr_sh_q;
        pulse_act_q <= pulse_sh_q;
      end
    end
  end

  assign pace    = pace_q;
  assign alarm   = alarm_q;
  assign state_o = state_q;

`ifdef PACE_STATS_EN
  logic [STAT_BITS-1:0] paced_q, sensed_q;

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      paced_q  <= '0;
      sensed_q <= '0;
    end else begin
      if (paced_ev && (paced_q != '1)) begin
        paced_q <= paced_q + STAT_BITS'(1);
      end
      if (sensed_ev && (sensed_q != '1)) begin
        sensed_q <= sensed_q + STAT_BITS'(1);
      end
    end
  end

  assign paced_cnt  = paced_q;
  assign sensed_cnt = sensed_q;
`else
  logic unused_stats_ev;
  assign unused_stats_ev = paced_ev ^ sensed_ev;
`endif

endmodule

// File: tb/tb_pace_scheduler.sv
// Directed bench for pace_scheduler with a per-cycle expected-output scoreboard.
module tb_pace_scheduler;

  localparam int unsigned CB = 8;
  localparam int unsigned PB = 4;
  localparam int unsigned SB = 8;

  localparam logic [1:0] SI = 2'd0;
  localparam logic [1:0] SA = 2'd1;
  localparam logic [1:0] SP = 2'd2;
  localparam logic [1:0] SR = 2'd3;

  logic          clk_2 = 1'b0;
  logic          reset_n, tick, enable, beat_sense, cfg_we, alarm_clr;
  logic [CB-1:0] escape_lim, refr_lim;
  logic [PB-1:0] pulse_len;
  logic          pace, alarm;
  logic [1:0]    state_o;
`ifdef PACE_STATS_EN
  logic [SB-1:0] paced_cnt, sensed_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [1:0] st;
    logic       pc;
    logic       al;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk_2 = ~clk_2;

  pace_scheduler #(
    .CNT_BITS   (CB),
    .PULSE_BITS (PB),
    .STAT_BITS  (SB)
  ) dut (
    .clk_2      (clk_2),
    .reset_n    (reset_n),
    .tick       (tick),
    .enable     (enable),
    .beat_sense (beat_sense),
    .cfg_we     (cfg_we),
    .escape_lim (escape_lim),
    .refr_lim   (refr_lim),
    .pulse_len  (pulse_len),
    .alarm_clr  (alarm_clr),
    .pace       (pace),
    .alarm      (alarm),
    .state_o    (state_o)
`ifdef PACE_STATS_EN
    ,
    .paced_cnt  (paced_cnt),
    .sensed_cnt (sensed_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] st, input logic pc, input logic al, input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(exp_t'{st: st, pc: pc, al: al});
    end
  endtask

  // Advance n cycles, comparing outputs 1 time unit after each edge against the queue.
  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_2);
      #1;
      cyc++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_underflow cyc=%0d observed=empty expected=entry", cyc);
      end else begin
        e = sb_q.pop_front();
        check("state", 32'(state_o), 32'(e.st));
        check("pace", 32'(pace), 32'(e.pc));
        check("alarm", 32'(alarm), 32'(e.al));
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    tick       = 1'b1;
    beat_sense = 1'b0;
    cfg_we     = 1'b0;
    alarm_clr  = 1'b0;
    escape_lim = '0;
    refr_lim   = '0;
    pulse_len  = '0;
    push(SI, 1'b0, 1'b0, 2);
    run(2);
`ifdef PACE_STATS_EN
    check("paced_rst", 32'(paced_cnt), 32'd0);
    check("sensed_rst", 32'(sensed_cnt), 32'd0);
`endif

    // Load 5/3/2 while still idle, then enable.
    reset_n    = 1'b1;
    cfg_we     = 1'b1;
    escape_lim = 8'd5;
    refr_lim   = 8'd3;
    pulse_len  = 4'd2;
    push(SI, 1'b0, 1'b0, 1);
    run(1);
    cfg_we = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push(SA, 1'b0, 1'b0, 5);
      push(SP, 1'b1, 1'b0, 2);
      push(SR, 1'b0, 1'b0, 3);
    end
    run(20);

    // Beat two ticks into ALERT inhibits the pulse.
    push(SA, 1'b0, 1'b0, 2);
    run(2);
    beat_sense = 1'b1;
    push(SA, 1'b0, 1'b0, 1);
    run(1);
    beat_sense = 1'b0;
    push(SA, 1'b0, 1'b0, 1);
    push(SR, 1'b0, 1'b0, 3);
    push(SA, 1'b0, 1'b0, 3);
    run(7);

    // Beat arriving in the cycle the escape would expire: beat wins.
    beat_sense = 1'b1;
    push(SA, 1'b0, 1'b0, 1);
    run(1);
    beat_sense = 1'b0;
    push(SA, 1'b0, 1'b0, 1);
    push(SR, 1'b0, 1'b0, 1);
    run(2);

    // Refractory beat with ticks frozen: sticky alarm, clear, then set-wins.
    tick       = 1'b0;
    beat_sense = 1'b1;
    push(SR, 1'b0, 1'b0, 1);
    run(1);
    beat_sense = 1'b0;
    push(SR, 1'b0, 1'b0, 1);
    push(SR, 1'b0, 1'b1, 2);
    run(3);
    alarm_clr = 1'b1;
    push(SR, 1'b0, 1'b0, 1);
    run(1);
    alarm_clr  = 1'b0;
    beat_sense = 1'b1;
    push(SR, 1'b0, 1'b0, 1);
    run(1);
    beat_sense = 1'b0;
    push(SR, 1'b0, 1'b0, 1);
    run(1);
    alarm_clr = 1'b1;
    push(SR, 1'b0, 1'b1, 1);
    run(1);
    alarm_clr = 1'b0;
    push(SR, 1'b0, 1'b1, 1);
    run(1);

    tick = 1'b1;
    push(SR, 1'b0, 1'b1, 2);
    push(SA, 1'b0, 1'b1, 1);
    run(3);
    alarm_clr = 1'b1;
    push(SA, 1'b0, 1'b0, 1);
    run(1);

    // Escape 10 loaded mid-window: this window still ends at 5, the next at 10.
    alarm_clr  = 1'b0;
    cfg_we     = 1'b1;
    escape_lim = 8'd10;
    push(SA, 1'b0, 1'b0, 1);
    run(1);
    cfg_we = 1'b0;
    push(SA, 1'b0, 1'b0, 2);
    push(SP, 1'b1, 1'b0, 2);
    push(SR, 1'b0, 1'b0, 3);
    push(SA, 1'b0, 1'b0, 10);
    push(SP, 1'b1, 1'b0, 1);
    run(18);
`ifdef PACE_STATS_EN
    check("paced_mid", 32'(paced_cnt), 32'd4);
    check("sensed_mid", 32'(sensed_cnt), 32'd2);
`endif

    // Disable during PACE drops pace on the next edge.
    enable = 1'b0;
    push(SI, 1'b0, 1'b0, 2);
    run(2);
    enable = 1'b1;
    push(SA, 1'b0, 1'b0, 10);
    push(SP, 1'b1, 1'b0, 1);
    run(11);

    // Reset mid-pulse, then the default 200/2/60 windows come back.
    reset_n = 1'b0;
    push(SI, 1'b0, 1'b0, 2);
    run(2);
`ifdef PACE_STATS_EN
    check("paced_rst2", 32'(paced_cnt), 32'd0);
    check("sensed_rst2", 32'(sensed_cnt), 32'd0);
`endif
    reset_n = 1'b1;
    push(SA, 1'b0, 1'b0, 200);
    push(SP, 1'b1, 1'b0, 2);
    push(SR, 1'b0, 1'b0, 60);
    push(SA, 1'b0, 1'b0, 1);
    run(263);

    // Zero limits behave as one-tick windows.
    cfg_we     = 1'b1;
    escape_lim = 8'd0;
    refr_lim   = 8'd0;
    pulse_len  = 4'd0;
    enable     = 1'b0;
    push(SI, 1'b0, 1'b0, 1);
    run(1);
    cfg_we = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push(SA, 1'b0, 1'b0, 1);
      push(SP, 1'b1, 1'b0, 1);
      push(SR, 1'b0, 1'b0, 1);
    end
    run(6);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

`ifdef PACE_STATS_EN
    // About 300 further pulses at one per three cycles: paced_cnt saturates.
    for (int k = 0; k < 900; k++) begin
      @(posedge clk_2);
    end
    #1;
    check("paced_sat", 32'(paced_cnt), 32'd255);
    check("sensed_none", 32'(sensed_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pace_scheduler.md
# pace_scheduler

Demand-pacing scheduler that sequences the pacemaker stimulus path. It senses the synchronised heartbeat input, times the escape and refractory windows in ticks of an external timebase, fires a stimulus pulse when no beat arrives in time, and flags beats that arrive during refractory (tachycardia). It sits between the switch/LED board I/O and the pacing output, and a board-level top configures it through a small register load port.

## Interface
- CNT_BITS, 8, width of interval counter and of the escape/refractory limits
- PULSE_BITS, 4, width of pulse-length field
- STAT_BITS, 8, width of the statistics counters (PACE_STATS_EN only)
- clk_2  in  1  single system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- tick  in  1  one-cycle timebase strobe; all interval counting advances only on tick
- enable  in  1  pacing enable; low forces IDLE
- beat_sense  in  1  asynchronous sensed-beat level
- cfg_we  in  1  load escape_lim, refr_lim and pulse_len into shadow registers
- escape_lim  in  CNT_BITS  ticks allowed without a beat before pacing
- refr_lim  in  CNT_BITS  refractory length in ticks
- pulse_len  in  PULSE_BITS  stimulus width in ticks
- alarm_clr  in  1  clears sticky alarm
- pace  out  1  stimulus output, registered
- alarm  out  1  sticky tachycardia flag
- state_o  out  2  current FSM state
- paced_cnt, sensed_cnt  out  STAT_BITS each  (PACE_STATS_EN only)

## Operation
- States: IDLE=0, ALERT=1, PACE=2, REFRACT=3.
- Reset values: state IDLE, counter 0, pace 0, alarm 0, shadow escape_lim=200, refr_lim=60, pulse_len=2, stats 0.
- Sense path: 2-flop synchroniser, then rising-edge detect giving beat_rise for one cycle.
- IDLE: enable=1 -> ALERT, counter cleared.
- ALERT: beat_rise -> REFRACT, counter cleared (inhibited beat). Else on tick, counter+1; when the incremented value equals the active escape_lim -> PACE, counter cleared.
- PACE: pace=1 throughout. On tick, counter+1; at pulse_len -> REFRACT, counter cleared. beat_rise is ignored.
- REFRACT: beat_rise -> alarm=1 (sticky), state unchanged. On tick, counter+1; at refr_lim -> ALERT, counter cleared.
- enable=0 in any state -> IDLE next cycle, pace drops the same edge, counter cleared; alarm is preserved.
- Limits of 0 are treated as 1. Comparisons are unsigned, CNT_BITS wide. The counter never wraps because it is cleared at each limit.
- Config: cfg_we loads the shadow registers any cycle. The active copy is taken from the shadow on each entry to REFRACT and on IDLE->ALERT, so a window in progress never changes length.
- Alarm: alarm_clr clears it; if alarm_clr and a refractory beat_rise occur in the same cycle, set wins.

## Timing
- beat_sense sampled high at edge k gives beat_rise in cycle k+1, and the state changes at edge k+2.
- pace asserts on the same edge that state becomes PACE and deasserts on the edge that leaves PACE.
- Simultaneous beat_rise and escape-expiring tick in ALERT: the beat wins, giving REFRACT with no pulse.
- Reset mid-pulse: pace is 0 on the next edge.
- Reset and enable=0 take priority over all other events, in that order.

## Configuration
- PACE_STATS_EN defined: paced_cnt increments on each ALERT->PACE transition, and sensed_cnt increments on each ALERT beat_rise. Both counters saturate at all-ones and are cleared by reset only.
- PACE_STATS_EN undefined: the counters and their ports are absent.

## Structure
- Package pace_pkg holds:
  - the state enum pace_state_t (2-bit, encodings above)
  - the default limit constants DEF_ESCAPE=200, DEF_REFR=60, DEF_PULSE=2
- Sub-module beat_sync contains the 2-flop synchroniser plus rising-edge detector (clk_2, reset_n, beat_sense in, beat_rise out).

## Test plan
- Reset, then enable=1 with tick every cycle, escape_lim=5, refr_lim=3, pulse_len=2, and no beats:
  - PACE is entered 5 ticks after ALERT
  - pace is high for exactly 2 cycles
  - REFRACT lasts 3 ticks, then the cycle repeats
- Same config, with beat_sense pulsed high 2 ticks into ALERT: state goes to REFRACT 2 cycles after sampling, with no pace.
- beat_sense pulsed mid-REFRACT:
  - alarm=1 and stays at 1
  - alarm_clr clears it
  - a same-cycle alarm_clr plus beat leaves alarm=1
- cfg_we with escape_lim=10 issued mid-ALERT: the current window still ends at 5, and the next window ends at 10.
- enable=0 during PACE: state goes to IDLE and pace=0 next edge. reset_n=0 mid-PACE: all outputs return to their reset values.
- With PACE_STATS_EN defined, after 300 paced cycles paced_cnt=255 (saturated).
